mac_accum_seq: RTL and testbench



---
 rtl/mac_accum_seq_if.sv | 53 +++++
 rtl/mac_accum_seq.sv | 139 +++++++++++++
 tb/tb_mac_accum_seq.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_accum_seq_if.sv
// Port bundle for mac_accum_seq: command, operand stream, external MAC link and result.
// Handshakes (operand and result): a transfer happens at a rising edge where valid and
// ready are both high; the source holds data and valid stable until that edge, and
// valid never waits on ready.
interface mac_accum_seq_if #(
   parameter int N_SIG   = 23,
   parameter int N_EXP   = 8,
   parameter int N_LEN_W = 16
);
   localparam int N_DATA = N_EXP + N_SIG + 1;

   logic               start;
   logic [N_LEN_W-1:0] len;
   logic [2:0]         rnd;

   logic               in_valid;
   logic               in_ready;
   logic [N_DATA-1:0]  in_a;
   logic [N_DATA-1:0]  in_b;

   logic [N_DATA-1:0]  mac_a;
   logic [N_DATA-1:0]  mac_b;
   logic [N_DATA-1:0]  mac_c;
   logic [2:0]         mac_rnd;
   logic [N_DATA-1:0]  mac_z;
   logic [7:0]         mac_status;

   logic               out_valid;
   logic               out_ready;
   logic [N_DATA-1:0]  out_data;
   logic [7:0]         out_status;
   logic               busy;

   modport master (
      output start, len, rnd,
      output in_valid, in_a, in_b,
      output mac_z, mac_status,
      output out_ready,
      input  in_ready,
      input  mac_a, mac_b, mac_c, mac_rnd,
      input  out_valid, out_data, out_status, busy
   );

   modport slave (
      input  start, len, rnd,
      input  in_valid, in_a, in_b,
      input  mac_z, mac_status,
      input  out_ready,
      output in_ready,
      output mac_a, mac_b, mac_c, mac_rnd,
      output out_valid, out_data, out_status, busy
   );
endinterface

// File: rtl/mac_accum_seq.sv
// Dot-product sequencer around an external combinational FP32 fused multiply-add:
// streams operand pairs into the MAC with the running sum on the addend, one pair per cycle.
module mac_accum_seq #(
   parameter int N_SIG   = 23,
   parameter int N_EXP   = 8,
   parameter int N_LEN_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   mac_accum_seq_if.slave       bus,
   output logic [1:0]           o_dbg_state
);
   localparam int N_DATA = N_EXP + N_SIG + 1;
   localparam logic [N_LEN_W-1:0] CNT_ONE = {{(N_LEN_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [N_DATA-1:0]  r_acc;
   logic [N_DATA-1:0]  r_op_a;
   logic [N_DATA-1:0]  r_op_b;
   logic               r_op_vld;
   logic [N_LEN_W-1:0] r_cnt;
   logic [2:0]         r_rnd_q;
   logic [7:1]         r_sticky;
   logic               r_last_zero;

   logic               w_cnt_zero;
   logic               w_accept;

   assign w_cnt_zero = (r_cnt == '0);
   assign w_accept   = (r_state == ST_RUN) && bus.in_valid && !w_cnt_zero;

   // MAC operands come straight from registers so the MAC sees a full cycle.
   assign bus.mac_a   = r_op_a;
   assign bus.mac_b   = r_op_b;
   assign bus.mac_c   = r_acc;
   assign bus.mac_rnd = r_rnd_q;

   // Zero flag tracks only the final sum; the other flags accumulate over the run.
   assign bus.out_data   = r_acc;
   assign bus.out_status = {r_sticky, r_last_zero};

   assign o_dbg_state = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_state_nxt = (bus.len != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (r_op_vld && w_cnt_zero && !w_accept) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b1;
      case (r_state)
         ST_IDLE: bus.busy      = 1'b0;
         ST_RUN:  bus.in_ready  = !w_cnt_zero;
         ST_DONE: bus.out_valid = 1'b1;
         default: bus.busy      = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc       <= '0;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_op_vld    <= 1'b0;
         r_cnt       <= '0;
         r_rnd_q     <= '0;
         r_sticky    <= '0;
         r_last_zero <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_acc       <= '0;
                  r_op_a      <= '0;
                  r_op_b      <= '0;
                  r_op_vld    <= 1'b0;
                  r_cnt       <= bus.len;
                  r_rnd_q     <= bus.rnd;
                  r_sticky    <= '0;
                  // An empty run reports an exact zero sum.
                  r_last_zero <= (bus.len == '0);
               end
            end
            ST_RUN: begin
               if (w_accept) begin
                  r_op_a   <= bus.in_a;
                  r_op_b   <= bus.in_b;
                  r_op_vld <= 1'b1;
                  r_cnt    <= r_cnt - CNT_ONE;
               end else begin
                  r_op_vld <= 1'b0;
               end
               if (r_op_vld) begin
                  r_acc       <= bus.mac_z;
                  r_sticky    <= r_sticky | bus.mac_status[7:1];
                  r_last_zero <= bus.mac_status[0];
               end
            end
            default: begin
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mac_accum_seq.sv
// Bench for mac_accum_seq: directed dot products against a table-driven MAC stand-in,
// results checked by a queue-based monitor on the output handshake.
module tb_mac_accum_seq;
   localparam logic [31:0] F0   = 32'h00000000;
   localparam logic [31:0] F1   = 32'h3F800000;
   localparam logic [31:0] F2   = 32'h40000000;
   localparam logic [31:0] F3   = 32'h40400000;
   localparam logic [31:0] F4   = 32'h40800000;
   localparam logic [31:0] F5   = 32'h40A00000;
   localparam logic [31:0] F6   = 32'h40C00000;
   localparam logic [31:0] F14  = 32'h41600000;
   localparam logic [31:0] F32  = 32'h42000000;
   localparam logic [31:0] FMAX = 32'h7F7FFFFF;
   localparam logic [31:0] FINF = 32'h7F800000;
   localparam logic [31:0] FNAN = 32'h7FC00000;

   logic        clk;
   logic        rst;
   logic [1:0]  dbg_state;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [39:0] exp_q[$];
   logic [39:0] mon_exp;

   mac_accum_seq_if bus ();

   mac_accum_seq dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual still running required finished");
      $fatal(1, "watchdog expired");
   end

   // MAC stand-in: exact FMA results for the operand triples used below, {status, z}.
   function automatic logic [39:0] mac_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
      case ({a, b, c})
         {F1, F4, F0}:       return {8'h00, F4};
         {F2, F5, F4}:       return {8'h00, F14};
         {F3, F6, F14}:      return {8'h00, F32};
         {F1, F1, F0}:       return {8'h00, F1};
         {F1, F1, F1}:       return {8'h00, F2};
         {F1, F1, F2}:       return {8'h00, F3};
         {F1, F1, F3}:       return {8'h00, F4};
         {FMAX, FMAX, F0}:   return {8'h32, FINF};
         {FMAX, FMAX, FINF}: return {8'h32, FINF};
         {FINF, F0, F0}:     return {8'h04, FNAN};
         {F1, F1, FNAN}:     return {8'h00, FNAN};
         {F2, F3, F0}:       return {8'h00, F6};
         default:            return {8'h00, 32'hDEADBEEF};
      endcase
   endfunction

   always_comb begin
      {bus.mac_status, bus.mac_z} = mac_ref(bus.mac_a, bus.mac_b, bus.mac_c);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: actual %h/%h required none",
                     bus.out_data, bus.out_status);
         end else begin
            mon_exp = exp_q.pop_front();
            check("result_data", 64'(bus.out_data), 64'(mon_exp[31:0]));
            check("result_status", 64'(bus.out_status), 64'(mon_exp[39:32]));
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [15:0] n, input logic [2:0] r);
      bus.start = 1'b1;
      bus.len   = n;
      bus.rnd   = r;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
      bit taken = 1'b0;
      int guard = 0;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      while (!taken && guard < 40) begin
         taken = bus.in_ready;
         tick();
         guard++;
      end
      bus.in_valid = 1'b0;
      if (!taken) check("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_done();
      int guard = 0;
      while (!bus.out_valid && guard < 40) begin
         tick();
         guard++;
      end
      check("done_reached", 64'(bus.out_valid), 64'd1);
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (bus.busy && guard < 40) begin
         tick();
         guard++;
      end
      check("idle_reached", 64'(bus.busy), 64'd0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_ctl"}, 64'({bus.in_ready, bus.out_valid, bus.busy, bus.mac_rnd,
                                 bus.out_status, dbg_state}), 64'd0);
      check({name, "_data"}, 64'(bus.out_data), 64'd0);
      check({name, "_mac"}, {bus.mac_a, bus.mac_b}, 64'd0);
      check({name, "_mac_c"}, 64'(bus.mac_c), 64'd0);
   endtask

   initial begin
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.len      = '0;
      bus.rnd      = '0;
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      bus.out_ready = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      // basic dot product, gapless
      bus.out_ready = 1'b1;
      exp_q.push_back({8'h00, F32});
      start_op(16'd3, 3'd0);
      check("start_in_ready", 64'(bus.in_ready), 64'd1);
      send_pair(F1, F4);
      send_pair(F2, F5);
      send_pair(F3, F6);
      check("last_in_ready", 64'(bus.in_ready), 64'd0);
      check("valid_not_early", 64'(bus.out_valid), 64'd0);
      tick();
      check("valid_latency", 64'(bus.out_valid), 64'd1);
      wait_idle();

      // zero length
      bus.out_ready = 1'b0;
      exp_q.push_back({8'h01, F0});
      start_op(16'd0, 3'd0);
      check("zero_valid", 64'(bus.out_valid), 64'd1);
      check("zero_in_ready", 64'(bus.in_ready), 64'd0);
      check("zero_state", 64'(dbg_state), 64'd2);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("zero_idle", 64'(bus.busy), 64'd0);

      // gaps and backpressure
      exp_q.push_back({8'h00, F4});
      start_op(16'd4, 3'd0);
      send_pair(F1, F1);
      tick();
      send_pair(F1, F1);
      tick();
      send_pair(F1, F1);
      tick();
      send_pair(F1, F1);
      check("bp_in_ready_off", 64'(bus.in_ready), 64'd0);
      wait_done();
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
         check("bp_hold_data", 64'(bus.out_data), 64'(F4));
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("bp_idle", 64'(bus.busy), 64'd0);

      // overflow
      bus.out_ready = 1'b1;
      exp_q.push_back({8'h32, FINF});
      start_op(16'd2, 3'd0);
      send_pair(FMAX, FMAX);
      send_pair(FMAX, FMAX);
      wait_done();
      wait_idle();

      // invalid
      exp_q.push_back({8'h04, FNAN});
      start_op(16'd2, 3'd0);
      send_pair(FINF, F0);
      send_pair(F1, F1);
      wait_done();
      wait_idle();

      // start pulses during RUN and DONE are ignored
      bus.out_ready = 1'b0;
      exp_q.push_back({8'h00, F32});
      start_op(16'd3, 3'd0);
      send_pair(F1, F4);
      bus.start = 1'b1;
      bus.len   = 16'd7;
      send_pair(F2, F5);
      bus.start = 1'b0;
      bus.len   = 16'd0;
      send_pair(F3, F6);
      wait_done();
      bus.start = 1'b1;
      bus.len   = 16'd7;
      tick();
      bus.start = 1'b0;
      bus.len   = 16'd0;
      check("done_held", 64'(bus.out_valid), 64'd1);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("start_ignored_idle", 64'(bus.busy), 64'd0);

      // reset in the middle of a run
      start_op(16'd3, 3'd3);
      send_pair(F1, F4);
      check("run_mac_rnd", 64'(bus.mac_rnd), 64'd3);
      send_pair(F2, F5);
      rst = 1'b1;
      #1;
      check_all_zero("midrun_reset");
      tick();
      rst = 1'b0;
      tick();

      // fresh run after reset
      bus.out_ready = 1'b1;
      exp_q.push_back({8'h00, F6});
      start_op(16'd1, 3'd0);
      send_pair(F2, F3);
      wait_done();
      wait_idle();
      repeat (2) tick();

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
